sdram_port_arbiter: RTL and testbench

- Shares the single Avalon-MM slave port of the SDRAM controller between two requesters.
- Requester 0 is the high-priority video/frame-buffer reader. Requester 1 is the general-purpose master (game logic / blitter).
- Provides fixed priority with starvation relief, a lock while a stalled command is held, and in-order routing of pipelined read data via an outstanding-read ID FIFO.

---
 rtl/sdram_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares the SDRAM controller's single Avalon-MM slave port between two
//   requesters. Requester 0 is the video/frame-buffer reader and has fixed
//   priority. Requester 1 is the general-purpose master; it is protected
//   from starvation by a counter that forces one m1 grant after
//   STARVE_LIMIT back-to-back m0 grants. A stalled command is locked until
//   the controller accepts it. Read data comes back in order, and an ID FIFO
//   routes each returned word to the requester that issued the read.
//
// Ports
//   clk_clk, reset_reset_n      clock, asynchronous active-low reset
//   m0_* / m1_*                 Avalon-MM slave ports facing the requesters
//   s_*                         Avalon-MM master port facing the SDRAM controller
//   pending_count               number of reads still outstanding
//   err_orphan                  sticky; set when read data returns with nothing outstanding
//
// Lock states
//   state    | meaning
//   ST_IDLE  | no command held; the grant follows priority and starvation relief
//   ST_LOCK0 | m0 command stalled by the controller; m0 keeps the port
//   ST_LOCK1 | m1 command stalled by the controller; m1 keeps the port
module sdram_port_arbiter #(
    parameter int ADDR_W       = 25,
    parameter int DATA_W       = 32,
    parameter int PEND_MAX     = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    input  logic [ADDR_W-1:0]           m0_address,
    input  logic                        m0_read,
    input  logic                        m0_write,
    input  logic [DATA_W-1:0]           m0_writedata,
    input  logic [DATA_W/8-1:0]         m0_byteenable,
    output logic                        m0_waitrequest,
    output logic [DATA_W-1:0]           m0_readdata,
    output logic                        m0_readdatavalid,
    input  logic [ADDR_W-1:0]           m1_address,
    input  logic                        m1_read,
    input  logic                        m1_write,
    input  logic [DATA_W-1:0]           m1_writedata,
    input  logic [DATA_W/8-1:0]         m1_byteenable,
    output logic                        m1_waitrequest,
    output logic [DATA_W-1:0]           m1_readdata,
    output logic                        m1_readdatavalid,
    output logic [ADDR_W-1:0]           s_address,
    output logic                        s_read,
    output logic                        s_write,
    output logic [DATA_W-1:0]           s_writedata,
    output logic [DATA_W/8-1:0]         s_byteenable,
    input  logic                        s_waitrequest,
    input  logic [DATA_W-1:0]           s_readdata,
    input  logic                        s_readdatavalid,
    output logic [$clog2(PEND_MAX):0]   pending_count,
    output logic                        err_orphan
);

    localparam int PW = $clog2(PEND_MAX);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOCK0, ST_LOCK1} state_t;

    state_t           state, state_nxt;
    logic             req0, req1;
    logic             gnt0, gnt1;
    logic             sel_read, sel_write;
    logic             cmd_driven, accept;
    logic             push, pop;
    logic             fifo_empty, fifo_not_full;
    logic [SW-1:0]    starve_cnt;
    logic [PW:0]      fifo_cnt;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             id_mem [PEND_MAX];
    logic             head_id;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // State register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state <= ST_IDLE;
        else                state <= state_nxt;
    end

    // Next state: lock onto whoever is driving a stalled command, release otherwise
    always_comb begin
        state_nxt = ST_IDLE;
        if (cmd_driven && s_waitrequest)
            state_nxt = gnt1 ? ST_LOCK1 : ST_LOCK0;
    end

    // Grant; forced off while reset is asserted so the port is quiet immediately
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_reset_n) begin
            case (state)
                ST_LOCK0: gnt0 = 1'b1;
                ST_LOCK1: gnt1 = 1'b1;
                default: begin
                    if (req1 && starve_cnt == SW'(STARVE_LIMIT)) gnt1 = 1'b1;
                    else if (req0)                               gnt0 = 1'b1;
                    else if (req1)                               gnt1 = 1'b1;
                end
            endcase
        end
    end

    // Downstream command mux; read wins over a simultaneous write
    assign sel_read  = (gnt0 & m0_read) | (gnt1 & m1_read);
    assign sel_write = ((gnt0 & m0_write) | (gnt1 & m1_write)) & ~sel_read;

    assign fifo_empty    = (fifo_cnt == '0);
    assign fifo_not_full = (fifo_cnt < (PW+1)'(PEND_MAX));

    assign s_read       = sel_read & fifo_not_full;
    assign s_write      = sel_write;
    assign s_address    = gnt1 ? m1_address    : (gnt0 ? m0_address    : '0);
    assign s_writedata  = gnt1 ? m1_writedata  : (gnt0 ? m0_writedata  : '0);
    assign s_byteenable = gnt1 ? m1_byteenable : (gnt0 ? m0_byteenable : '0);

    assign cmd_driven = s_read | s_write;
    assign accept     = cmd_driven & ~s_waitrequest;

    assign m0_waitrequest = ~(gnt0 & accept);
    assign m1_waitrequest = ~(gnt1 & accept);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            starve_cnt <= '0;
        end else if (!req1) begin
            starve_cnt <= '0;
        end else if (accept && gnt1) begin
            starve_cnt <= '0;
        end else if (accept && gnt0 && starve_cnt != SW'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Outstanding-read ID FIFO. A full FIFO never sees a push (reads are gated)
    // and an empty FIFO never sees a pop, so the count cannot wrap.
    assign push    = accept & s_read;
    assign pop     = s_readdatavalid & ~fifo_empty;
    assign head_id = id_mem[rd_ptr];

    always_ff @(posedge clk_clk) begin
        if (push) id_mem[wr_ptr] <= gnt1;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
            if (s_readdatavalid && fifo_empty) err_orphan <= 1'b1;
        end
    end

    assign pending_count    = fifo_cnt;
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = pop & ~head_id;
    assign m1_readdatavalid = pop &  head_id;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [24:0] m0_address, m1_address, s_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, s_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata, s_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        s_read, s_write, s_waitrequest, s_readdatavalid;
    logic [3:0]  pending_count;
    logic        err_orphan;

    int n_total  = 0;
    int n_passed = 0;

    sdram_port_arbiter dut (
        .clk_clk          (clk_clk),
        .reset_reset_n    (reset_reset_n),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_byteenable    (m0_byteenable),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_byteenable    (m1_byteenable),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .s_address        (s_address),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_writedata      (s_writedata),
        .s_byteenable     (s_byteenable),
        .s_waitrequest    (s_waitrequest),
        .s_readdata       (s_readdata),
        .s_readdatavalid  (s_readdatavalid),
        .pending_count    (pending_count),
        .err_orphan       (err_orphan)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs are changed #1 after the edge and outputs
    // are sampled #2 later, well away from the next rising edge.
    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        reset_reset_n   = 1'b0;
        m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
        m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest   = 1'b0;
        s_readdata      = '0;
        s_readdatavalid = 1'b0;

        // Reset state
        #12;
        chk("rst_m0_wait", m0_waitrequest, 1);
        chk("rst_m1_wait", m1_waitrequest, 1);
        chk("rst_s_read",  s_read, 0);
        chk("rst_s_write", s_write, 0);
        chk("rst_s_addr",  s_address, 0);
        chk("rst_pending", pending_count, 0);
        chk("rst_orphan",  err_orphan, 0);
        reset_reset_n = 1'b1;
        tick();

        // 1: uncontended write
        m1_write = 1; m1_address = 25'h00010; m1_writedata = 32'hDEADBEEF; m1_byteenable = 4'hF;
        settle();
        chk("t1_s_write", s_write, 1);
        chk("t1_s_read",  s_read, 0);
        chk("t1_s_addr",  s_address, 25'h00010);
        chk("t1_s_wdata", s_writedata, 32'hDEADBEEF);
        chk("t1_s_be",    s_byteenable, 4'hF);
        chk("t1_m1_wait", m1_waitrequest, 0);
        chk("t1_m0_wait", m0_waitrequest, 1);
        tick();
        m1_write = 0;
        settle();
        chk("t1_pending", pending_count, 0);

        // 2: simultaneous reads, in-order return routing
        m0_read = 1; m0_address = 25'h100;
        m1_read = 1; m1_address = 25'h200;
        settle();
        chk("t2_c0_addr",  s_address, 25'h100);
        chk("t2_c0_read",  s_read, 1);
        chk("t2_c0_m0w",   m0_waitrequest, 0);
        chk("t2_c0_m1w",   m1_waitrequest, 1);
        tick();
        m0_read = 0;
        settle();
        chk("t2_c1_addr",  s_address, 25'h200);
        chk("t2_c1_m1w",   m1_waitrequest, 0);
        tick();
        m1_read = 0;
        settle();
        chk("t2_pending2", pending_count, 2);
        s_readdatavalid = 1; s_readdata = 32'hAAAA0000;
        settle();
        chk("t2_r0_m0v",   m0_readdatavalid, 1);
        chk("t2_r0_m1v",   m1_readdatavalid, 0);
        chk("t2_r0_data",  m0_readdata, 32'hAAAA0000);
        tick();
        s_readdata = 32'hBBBB0000;
        settle();
        chk("t2_r1_m0v",   m0_readdatavalid, 0);
        chk("t2_r1_m1v",   m1_readdatavalid, 1);
        chk("t2_r1_data",  m1_readdata, 32'hBBBB0000);
        tick();
        s_readdatavalid = 0;
        settle();
        chk("t2_pending0", pending_count, 0);

        // 3: stall lock
        m1_read = 1; m1_address = 25'h300; s_waitrequest = 1;
        settle();
        chk("t3_s1_addr",  s_address, 25'h300);
        chk("t3_s1_m1w",   m1_waitrequest, 1);
        tick();
        m0_read = 1; m0_address = 25'h400;
        settle();
        chk("t3_s2_addr",  s_address, 25'h300);
        chk("t3_s2_m0w",   m0_waitrequest, 1);
        tick();
        s_waitrequest = 0;
        settle();
        chk("t3_c3_addr",  s_address, 25'h300);
        chk("t3_c3_m1w",   m1_waitrequest, 0);
        chk("t3_c3_m0w",   m0_waitrequest, 1);
        tick();
        m1_read = 0;
        settle();
        chk("t3_c4_addr",  s_address, 25'h400);
        chk("t3_c4_m0w",   m0_waitrequest, 0);
        tick();
        m0_read = 0;
        s_readdatavalid = 1;
        settle();
        chk("t3_ret0_m1v", m1_readdatavalid, 1);
        tick();
        settle();
        chk("t3_ret1_m0v", m0_readdatavalid, 1);
        tick();
        s_readdatavalid = 0;

        // 4: starvation relief with both requesters always writing
        m0_write = 1; m0_address = 25'h0A0;
        m1_write = 1; m1_address = 25'h0B0;
        for (int i = 0; i < 10; i++) begin
            settle();
            chk($sformatf("t4_m1w_%0d", i), m1_waitrequest, (i % 5 == 4) ? 1'b0 : 1'b1);
            chk($sformatf("t4_addr_%0d", i), s_address, (i % 5 == 4) ? 25'h0B0 : 25'h0A0);
            tick();
        end
        m0_write = 0; m1_write = 0;

        // 5: FIFO full
        m0_read = 1;
        for (int i = 0; i < 8; i++) begin
            m0_address = 25'h1000 + 25'(i);
            settle();
            chk($sformatf("t5_acc_%0d", i), m0_waitrequest, 0);
            tick();
        end
        m0_address = 25'h1008;
        settle();
        chk("t5_full_sread", s_read, 0);
        chk("t5_full_m0w",   m0_waitrequest, 1);
        chk("t5_full_cnt",   pending_count, 8);
        tick();
        m0_read = 0; m1_write = 1; m1_address = 25'h2000;
        settle();
        chk("t5_wr_m1w",     m1_waitrequest, 0);
        chk("t5_wr_swrite",  s_write, 1);
        tick();
        m1_write = 0; m0_read = 1;
        settle();
        chk("t5_wr_cnt",     pending_count, 8);
        chk("t5_still_m0w",  m0_waitrequest, 1);
        s_readdatavalid = 1;
        settle();
        chk("t5_pop_m0v",    m0_readdatavalid, 1);
        tick();
        s_readdatavalid = 0;
        settle();
        chk("t5_cnt7",       pending_count, 7);
        chk("t5_9th_sread",  s_read, 1);
        chk("t5_9th_m0w",    m0_waitrequest, 0);
        tick();
        m0_read = 0;
        settle();
        chk("t5_cnt8",       pending_count, 8);
        s_readdatavalid = 1;
        for (int i = 0; i < 8; i++) tick();
        s_readdatavalid = 0;
        settle();
        chk("t5_drained",    pending_count, 0);

        // 6: orphan data, then reset with reads pending
        s_readdatavalid = 1;
        settle();
        chk("t6_orph_m0v",   m0_readdatavalid, 0);
        chk("t6_orph_m1v",   m1_readdatavalid, 0);
        tick();
        s_readdatavalid = 0;
        settle();
        chk("t6_orphan",     err_orphan, 1);
        m0_read = 1;
        for (int i = 0; i < 3; i++) tick();
        m1_read = 1;
        settle();
        chk("t6_pend3",      pending_count, 3);
        reset_reset_n = 0;
        #1;
        chk("t6_rst_cnt",    pending_count, 0);
        chk("t6_rst_orphan", err_orphan, 0);
        chk("t6_rst_m0w",    m0_waitrequest, 1);
        chk("t6_rst_m1w",    m1_waitrequest, 1);
        chk("t6_rst_sread",  s_read, 0);
        chk("t6_rst_saddr",  s_address, 0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
